// File: rtl/mat_stream_pkg.sv
// Shared definitions for the result-matrix streaming path.
package mat_stream_pkg;

  localparam int unsigned N     = 3;
  localparam int unsigned W     = 9;
  localparam int unsigned IDX_W = $clog2(N * N);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/mat_elem_sel.sv
// Combinational N*N:1 element mux: picks element idx out of the packed hold word.
module mat_elem_sel #(
  parameter int unsigned N  = 3,
  parameter int unsigned W  = 9,
  parameter int unsigned IW = 4
) (
  input  logic [N*N*W-1:0] hold,
  input  logic [IW-1:0]    idx,
  output logic [W-1:0]     data
);

  // One-hot compare per element; out-of-range indices yield zero.
  always_comb begin
    data = '0;
    for (int unsigned k = 0; k < N * N; k++) begin
      if (idx == IW'(k)) data = hold[W*k +: W];
    end
  end

endmodule

// File: rtl/mat_result_streamer.sv
// Captures a packed N x N result matrix and streams it row-major on valid/ready.
module mat_result_streamer #(
  parameter int unsigned N = mat_stream_pkg::N,
  parameter int unsigned W = mat_stream_pkg::W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             res_valid,
  input  logic [N*N*W-1:0] res,
  output logic             res_ready,
  output logic [W-1:0]     m_data,
  output logic [1:0]       m_row,
  output logic [1:0]       m_col,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             drop_err
);

  import mat_stream_pkg::*;

  localparam int unsigned    NN       = N * N;
  localparam int unsigned    IW       = $clog2(NN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NN - 1);
  localparam logic [1:0]     COL_MAX  = 2'(N - 1);

  // Row/col tags are 2 bits wide, so larger matrices cannot be described.
  if (N > 4 || N < 2) begin : g_bad_n
    $error("mat_result_streamer: N must be in 2..4");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [NN*W-1:0]  hold_q, hold_d;
  logic             drop_q, drop_d;
  logic             at_last, cap, fire;

  mat_elem_sel #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_sel (
    .hold (hold_q),
    .idx  (idx_q),
    .data (m_data)
  );

  // State, counters, hold word and sticky error; rst wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  // Handshake decode and next-state; capture takes priority over wrap-to-IDLE
  // so a pulse on the final handshake restarts at element 0 without a bubble.
  always_comb begin
    at_last   = (idx_q == LAST_IDX);
    m_valid   = en & (state_q == STREAM);
    res_ready = en & ((state_q == IDLE) | ((state_q == STREAM) & at_last & m_ready));
    cap       = res_valid & res_ready;
    fire      = m_valid & m_ready;
    m_last    = at_last & m_valid;
    m_row     = row_q;
    m_col     = col_q;
    busy      = (state_q == STREAM);
    drop_err  = drop_q;

    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    hold_d  = hold_q;
    drop_d  = drop_q | (en & res_valid & ~res_ready);

    if (cap) begin
      state_d = STREAM;
      hold_d  = res;
      idx_d   = '0;
      row_d   = '0;
      col_d   = '0;
    end else if (fire) begin
      if (at_last) begin
        state_d = IDLE;
        idx_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = row_q + 2'd1;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer with hand-derived expected values.
module tb_mat_result_streamer;

  localparam int unsigned N = 3;
  localparam int unsigned W = 9;

  logic             clk = 1'b0;
  logic             rst, en, res_valid, m_ready;
  logic [N*N*W-1:0] res;
  logic             res_ready, m_last, m_valid, busy, drop_err;
  logic [W-1:0]     m_data;
  logic [1:0]       m_row, m_col;

  int n_chk  = 0;
  int n_pass = 0;

  mat_result_streamer #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .res_valid (res_valid),
    .res       (res),
    .res_ready (res_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // kind 0: element k = k+1; kind 1: element k = 511-k
  function automatic int ev(input int kind, input int k);
    return (kind == 0) ? (k + 1) : (511 - k);
  endfunction

  function automatic logic [N*N*W-1:0] mk(input int kind);
    logic [N*N*W-1:0] m;
    m = '0;
    for (int k = 0; k < 9; k++) m[W*k +: W] = W'(ev(kind, k));
    return m;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_elem(input int kind, input int k);
    chk($sformatf("valid[%0d]", k), 32'(m_valid), 1);
    chk($sformatf("data[%0d]", k), 32'(m_data), 32'(ev(kind, k)));
    chk($sformatf("row[%0d]", k), 32'(m_row), 32'(k / 3));
    chk($sformatf("col[%0d]", k), 32'(m_col), 32'(k % 3));
    chk($sformatf("last[%0d]", k), 32'(m_last), 32'(k == 8));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; res_valid = 1'b0; m_ready = 1'b0; res = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic load(input int kind);
    res = mk(kind);
    res_valid = 1'b1;
    #1;
    chk("load_ready", 32'(res_ready), 1);
    next_cycle();
    res_valid = 1'b0;
  endtask

  task automatic hs(input int kind, input int k);
    m_ready = 1'b1;
    #1;
    expect_elem(kind, k);
    next_cycle();
  endtask

  task automatic idle_check(input string tag, input logic exp_drop);
    #1;
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdy"}, 32'(res_ready), 1);
    chk({tag, "_last"}, 32'(m_last), 0);
    chk({tag, "_drop"}, 32'(drop_err), 32'(exp_drop));
    next_cycle();
  endtask

  initial begin
    int cnt;
    int cyc;
    logic [5:0] pat;
    pat = 6'b101001;  // bit i = m_ready on cycle i: 1,0,0,1,0,1

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_row", 32'(m_row), 0);
    chk("rst_col", 32'(m_col), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_rdy", 32'(res_ready), 1);
    next_cycle();

    // Single matrix, m_ready held high
    m_ready = 1'b1;
    load(0);
    for (int k = 0; k < 9; k++) hs(0, k);
    idle_check("single", 1'b0);

    // Backpressure with a repeating 1,0,0,1,0,1 ready pattern
    load(0);
    cnt = 0;
    cyc = 0;
    while (cnt < 9 && cyc < 60) begin
      m_ready = pat[cyc % 6];
      #1;
      expect_elem(0, cnt);
      if (m_ready) cnt++;
      next_cycle();
      cyc++;
    end
    chk("bp_count", 32'(cnt), 9);
    idle_check("bp", 1'b0);

    // Back-to-back: second pulse on the last handshake of the first matrix
    load(0);
    for (int k = 0; k < 8; k++) hs(0, k);
    m_ready = 1'b1;
    res = mk(1);
    res_valid = 1'b1;
    #1;
    expect_elem(0, 8);
    chk("b2b_rdy", 32'(res_ready), 1);
    next_cycle();
    res_valid = 1'b0;
    for (int k = 0; k < 9; k++) hs(1, k);
    idle_check("b2b", 1'b0);

    // en gating: freeze at index 3 for 5 cycles with an ignored pulse
    load(0);
    for (int k = 0; k < 3; k++) hs(0, k);
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      m_ready = 1'b1;
      res = mk(1);
      res_valid = (i == 2);
      #1;
      chk("en_valid", 32'(m_valid), 0);
      chk("en_rdy", 32'(res_ready), 0);
      next_cycle();
    end
    res_valid = 1'b0;
    en = 1'b1;
    for (int k = 3; k < 9; k++) hs(0, k);
    idle_check("en", 1'b0);

    // Drop: pulse while streaming index 4
    load(0);
    for (int k = 0; k < 4; k++) hs(0, k);
    m_ready = 1'b1;
    res = mk(1);
    res_valid = 1'b1;
    #1;
    expect_elem(0, 4);
    chk("drop_rdy", 32'(res_ready), 0);
    next_cycle();
    res_valid = 1'b0;
    chk("drop_set", 32'(drop_err), 1);
    for (int k = 5; k < 9; k++) hs(0, k);
    idle_check("drop", 1'b1);

    // Reset mid-stream at index 6, then a fresh matrix
    load(0);
    for (int k = 0; k < 6; k++) hs(0, k);
    m_ready = 1'b1;
    rst = 1'b1;
    #1;
    expect_elem(0, 6);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(m_valid), 0);
    chk("mrst_data", 32'(m_data), 0);
    chk("mrst_row", 32'(m_row), 0);
    chk("mrst_col", 32'(m_col), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_drop", 32'(drop_err), 0);
    chk("mrst_rdy", 32'(res_ready), 1);
    next_cycle();
    load(1);
    for (int k = 0; k < 9; k++) hs(1, k);
    idle_check("mrst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mat_result_streamer.md
# mat_result_streamer

Drains the 3x3 result matrix produced by the multiply array and streams it out one element per handshake, row-major. It captures the 81-bit parallel result word on a one-cycle `res_valid` pulse and presents elements on a valid/ready stream with row/column tags and a last flag. It sits between the array's `out` bus and any narrow consumer, such as a UART/AXI-stream bridge or an accumulation buffer.

## Interface
- `N`, 3: matrix dimension; element count is N*N.
- `W`, 9: result element width in bits.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `en` in 1: global enable; low freezes all state.
- `res_valid` in 1: one-cycle pulse, `res` holds a complete result matrix.
- `res` in N*N*W: packed result; element k = row*N+col at bits [W*k+W-1 : W*k].
- `res_ready` out 1: block can capture `res` this cycle.
- `m_data` out W: current element.
- `m_row`, `m_col` out 2 each: row and column of `m_data`.
- `m_last` out 1: high on element N*N-1.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready from consumer.
- `busy` out 1: a matrix is held and not fully drained.
- `drop_err` out 1: sticky; a result pulse arrived while `res_ready` was low.

## Operation
- **States:**
  - IDLE: `res_ready`=1, `m_valid`=0.
  - STREAM: `m_valid`=1, `busy`=1.
- **Capture:** `en & res_valid & res_ready` loads `res` into the hold register, sets index to 0 and the next state to STREAM.
- **Advance:** in STREAM, `en & m_valid & m_ready` increments the index.
  - If the index is N*N-1, the next state is IDLE.
  - If a capture happens in that same cycle, the state stays STREAM with index 0.
- **`res_ready`:** equals (state==IDLE) | (state==STREAM & index==N*N-1 & m_ready), gated by `en`. The `m_ready` to `res_ready` path is combinational, which is intentional and allows back-to-back matrices with no bubble.
- **Stream outputs:**
  - `m_data` = hold[W*idx +: W].
  - `m_row` = idx / N and `m_col` = idx % N, both kept as separate registered counters (col wraps at N-1 and increments row). No divider is used.
  - `m_last` = (idx==N*N-1) & `m_valid`.
- **Stability:** while `m_valid & !m_ready`, `m_data`/`m_row`/`m_col`/`m_last` hold stable.
- **`en`=0:**
  - `m_valid`=0 and `res_ready`=0.
  - No state, index or register changes.
  - `res_valid` pulses are ignored and do not set `drop_err`.
  - Deasserting `en` mid-stream then reasserting it resumes at the same index.
- **`drop_err`:** set when `en & res_valid & !res_ready`. The pulse is discarded and the held matrix is unaffected. It clears only on `rst`.
- **Width:** `res` and the hold register are N*N*W wide. `m_row`/`m_col` are 2 bits for N≤4. N>4 is unsupported (elaboration error).

## Timing
- Reset values: state IDLE, index/row/col 0, hold 0, `m_data` 0, `m_valid` 0, `m_last` 0, `busy` 0, `drop_err` 0. `res_ready` reads 1 after reset once `en`=1.
- `rst` overrides `en` and any in-flight stream. A reset mid-stream abandons the matrix, and the next cycle is IDLE.
- Latency: capture at edge t means `m_valid`=1 with element 0 from cycle t+1.
- Throughput: with `m_ready` held high, one element per cycle; N*N cycles per matrix; continuous with back-to-back captures.
- A consumer may hold `m_ready` high or toggle it arbitrarily. Elements are never skipped or repeated.

## Structure
- Package `mat_stream_pkg`: `N`, `W`, `IDX_W`=$clog2(N*N), and a state enum {IDLE, STREAM}. This package is shared with the future input-side loader.
- One sub-module, `mat_elem_sel`: a combinational N*N:1 element mux (hold word + index → `m_data`). The FSM, counters and hold register live in the top module.

## Test plan
- **Single matrix, `m_ready`=1:** `res` element k = k+1 → `m_data` 1..9 on consecutive cycles; row/col (0,0)…(2,2); `m_last` only on 9; state IDLE after.
- **Backpressure:** `m_ready` pattern 1,0,0,1,0,1… → every element appears exactly once in order; outputs stable during stalls.
- **Back-to-back:** second pulse (element k = 511-k) coincident with the last handshake of the first → no bubble; 18 contiguous elements; `drop_err`=0.
- **Drop:** pulse mid-stream at index 4 → `drop_err`=1, current stream continues unchanged with elements 5..9, state IDLE after.
- **`en` gating:** `en`=0 at index 3 for 5 cycles → `m_valid`=0 and a pulse is ignored (`drop_err` stays 0); after re-enable, the stream resumes at element 4.
- **Reset mid-stream:** `rst` at index 6 → next cycle all outputs at reset values; a new pulse streams from element 0.
